// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that lets NREQ byte producers share a
// single uart_tx serializer, with a per-frame watchdog and an inter-frame gap.
module uart_tx_sched #(
  parameter int NREQ        = 4,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic              uclk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   req_done,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    GAP
  } state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [GW-1:0]   gap_cnt;
  logic [WW-1:0]   wd_cnt;

  logic            found;
  logic [PW-1:0]   grant;
  logic [PW-1:0]   next_ptr;
  logic [PW:0]     sum;

  // Pick the first requesting index at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    grant = '0;
    sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ)) begin
        sum = sum - (PW+1)'(NREQ);
      end
      if (!found && req_valid[sum[PW-1:0]]) begin
        found = 1'b1;
        grant = sum[PW-1:0];
      end
    end
    next_ptr = (grant == PW'(NREQ - 1)) ? '0 : grant + PW'(1);
  end

  // Scheduler FSM: grant, launch, wait for completion or watchdog, then gap
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      req_ack     <= '0;
      req_done    <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ack     <= '0;
      req_done    <= '0;
      tx_en       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            tx_data        <= req_data[8*grant +: 8];
            tx_en          <= 1'b1;
            req_ack[grant] <= 1'b1;
            owner          <= grant;
            rr_ptr         <= next_ptr;
            busy           <= 1'b1;
            state          <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= BUSY;
        end
        BUSY: begin
          wd_cnt <= wd_cnt + WW'(1);
          if (tx_done || (wd_cnt == WW'(TIMEOUT_CYC - 1))) begin
            if (tx_done) begin
              req_done[owner] <= 1'b1;
            end else begin
              timeout_err <= 1'b1;
            end
            if (GAP_CYC == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(GAP_CYC - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a behavioural
// uart_tx stand-in that answers each launch with tx_done after FRAME cycles.
module tb_uart_tx_sched;

  localparam int NREQ  = 4;
  localparam int GAP   = 2;
  localparam int TMO   = 64;
  localparam int FRAME = 30;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic              uclk = 1'b0;
  logic              rst  = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [7:0]        data_arr [NREQ];
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_done;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_done = 1'b0;
  logic              busy;
  logic              timeout_err;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  exp_t       sb [$];
  logic [7:0] src_q [NREQ][$];
  int         model_ptr   = 0;
  bit         stub_enable = 1'b1;
  int         stub_cnt    = 0;
  bit         in_flight   = 1'b0;
  int         fl_owner    = 0;
  bit         done_prev   = 1'b0;
  int         last_launch = -1;
  bit         check_spacing = 1'b0;

  assign req_data = {data_arr[3], data_arr[2], data_arr[1], data_arr[0]};

  uart_tx_sched #(
    .NREQ        (NREQ),
    .GAP_CYC     (GAP),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .uclk        (uclk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .req_done    (req_done),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // 50 MHz clock
  always #10 uclk = ~uclk;

  // Cycle counter used for latency and spacing measurements
  always @(posedge uclk) cyc++;

  // Hard stop in case something wedges the whole run
  initial begin
    #5000000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] stopped");
  end

  // uart_tx stand-in plus launch/completion monitor, sampling on negedge
  initial begin : monitor
    logic [NREQ-1:0] exp_done;
    logic [NREQ-1:0] exp_ack;
    exp_t            e;
    forever begin
      @(negedge uclk);
      exp_done = done_prev ? (4'b0001 << fl_owner) : 4'b0000;
      if (done_prev) in_flight = 1'b0;
      checks++;
      if (req_done !== exp_done) begin
        fails++;
        $display("[TB] FAIL req_done at cycle %0d: got %b expected %b", cyc, req_done, exp_done);
      end
      done_prev = 1'b0;
      tx_done   = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0 && stub_enable) begin
          tx_done   = 1'b1;
          done_prev = 1'b1;
        end
      end
      if (tx_en === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("[TB] FAIL unexpected_launch at cycle %0d: tx_data %h with empty scoreboard", cyc, tx_data);
        end else begin
          e = sb.pop_front();
          exp_ack = 4'b0001 << e.idx;
          checks++;
          if (tx_data !== e.data) begin
            fails++;
            $display("[TB] FAIL tx_data at cycle %0d: got %h expected %h", cyc, tx_data, e.data);
          end
          checks++;
          if (req_ack !== exp_ack) begin
            fails++;
            $display("[TB] FAIL req_ack_grant at cycle %0d: got %b expected %b", cyc, req_ack, exp_ack);
          end
          fl_owner = e.idx;
        end
        in_flight = 1'b1;
        stub_cnt  = FRAME;
        if (check_spacing && last_launch >= 0) begin
          checks++;
          if (cyc - last_launch < FRAME + GAP + 2) begin
            fails++;
            $display("[TB] FAIL launch_spacing: got %0d cycles expected >= %0d", cyc - last_launch, FRAME + GAP + 2);
          end
        end
        last_launch = cyc;
      end else begin
        checks++;
        if (req_ack !== 4'b0000) begin
          fails++;
          $display("[TB] FAIL req_ack_idle at cycle %0d: got %b expected 0000", cyc, req_ack);
        end
      end
    end
  end

  // Build the expected grant order from the queued bytes with a round-robin model
  task automatic predict();
    int pos [NREQ];
    int total = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = 0;
      total += src_q[i].size();
    end
    for (int n = 0; n < total; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        int c = (model_ptr + k) % NREQ;
        if (pos[c] < src_q[c].size()) begin
          exp_t e;
          e.idx  = c;
          e.data = src_q[c][pos[c]];
          sb.push_back(e);
          pos[c]++;
          model_ptr = (c + 1) % NREQ;
          break;
        end
      end
    end
  endtask

  // Present queued bytes as requests until everything has been sent and retired
  task automatic run_traffic(input int bound, input string name);
    int  n = 0;
    bit  empty;
    forever begin
      @(negedge uclk);
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i[1:0]] === 1'b1 && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          req_valid[i[1:0]] = 1'b1;
          data_arr[i]       = src_q[i][0];
          empty             = 1'b0;
        end else begin
          req_valid[i[1:0]] = 1'b0;
        end
      end
      if (empty && sb.size() == 0 && !in_flight && busy === 1'b0) break;
      n++;
      if (n > bound) begin
        checks++;
        fails++;
        $display("[TB] FAIL %s_drain: %0d frames still expected after %0d cycles", name, sb.size(), bound);
        break;
      end
    end
  endtask

  // Async reset applied away from the clock edge; clears the bench model too
  task automatic do_reset();
    @(negedge uclk);
    #2 rst = 1'b1;
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    sb.delete();
    in_flight = 1'b0;
    stub_cnt  = 0;
    done_prev = 1'b0;
    model_ptr = 0;
    repeat (2) @(negedge uclk);
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) data_arr[i] = 8'h00;
    @(negedge uclk);
    checks++; if (tx_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_tx_en: got %b expected 0", tx_en); end
    checks++; if (tx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout_err: got %b expected 0", timeout_err); end
    checks++; if (req_ack !== 4'b0000) begin fails++; $display("[TB] FAIL reset_req_ack: got %b expected 0000", req_ack); end
    checks++; if (req_done !== 4'b0000) begin fails++; $display("[TB] FAIL reset_req_done: got %b expected 0000", req_done); end
    #2 rst = 1'b0;
    repeat (2) @(negedge uclk);
  endtask

  task automatic test_single();
    src_q[0].push_back(8'h55);
    predict();
    run_traffic(200, "single");
  endtask

  task automatic test_all_four();
    do_reset();
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(8'h10 + 8'(i));
    predict();
    run_traffic(400, "all_four");
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(8'h20 + 8'(i));
    predict();
    run_traffic(400, "refill");
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 4; k++) begin
      src_q[1].push_back(8'h41 + 8'(k));
      src_q[3].push_back(8'h61 + 8'(k));
    end
    predict();
    run_traffic(800, "alternate");
  endtask

  task automatic test_timeout();
    int   n = 0;
    exp_t e;
    int   t;
    stub_enable = 1'b0;
    e.idx  = 0;
    e.data = 8'hA5;
    sb.push_back(e);
    model_ptr = 1;
    @(negedge uclk);
    data_arr[0] = 8'hA5;
    req_valid   = 4'b0001;
    while (req_ack[0] !== 1'b1 && n < 50) begin @(negedge uclk); n++; end
    req_valid = 4'b0000;
    n = 0;
    while (timeout_err !== 1'b1 && n < 200) begin @(negedge uclk); n++; end
    t = cyc;
    checks++;
    if (timeout_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL timeout_seen: got %b expected 1", timeout_err);
    end
    checks++;
    if (t - last_launch != TMO + 1) begin
      fails++;
      $display("[TB] FAIL timeout_latency: got %0d cycles after launch expected %0d", t - last_launch, TMO + 1);
    end
    @(negedge uclk);
    checks++; if (timeout_err !== 1'b0) begin fails++; $display("[TB] FAIL timeout_pulse_width: got %b expected 0", timeout_err); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL timeout_gap_busy: got %b expected 1", busy); end
    @(negedge uclk);
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL timeout_busy_release: got %b expected 0", busy); end
    in_flight   = 1'b0;
    stub_cnt    = 0;
    stub_enable = 1'b1;
  endtask

  task automatic test_midframe_reset();
    int   n = 0;
    exp_t e;
    e.idx  = 1;
    e.data = 8'h77;
    sb.push_back(e);
    @(negedge uclk);
    data_arr[1] = 8'h77;
    req_valid   = 4'b0010;
    while (req_ack[1] !== 1'b1 && n < 50) begin @(negedge uclk); n++; end
    req_valid = 4'b0000;
    repeat (5) @(negedge uclk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_busy: got %b expected 0", busy); end
    in_flight = 1'b0;
    stub_cnt  = 0;
    done_prev = 1'b0;
    model_ptr = 0;
    sb.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge uclk);
      checks++; if (tx_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_hold_tx_en: got %b expected 0", tx_en); end
    end
    #2 rst = 1'b0;
    src_q[0].push_back(8'h3C);
    src_q[2].push_back(8'hC3);
    predict();
    run_traffic(300, "post_reset");
  endtask

  task automatic test_back_to_back();
    for (int b = 1; b <= 99; b++) src_q[2].push_back(8'(b));
    predict();
    check_spacing = 1'b1;
    last_launch   = -1;
    run_traffic(99 * (FRAME + GAP + 4) + 100, "back_to_back");
    check_spacing = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_timeout();
    test_midframe_reset();
    test_back_to_back();
    repeat (3) @(negedge uclk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
